// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal direction predictor: a table of saturating counters indexed by PC
// (optionally XOR global history), trained non-speculatively at branch resolution.

module pht_ctr #(
    parameter int CTR_BITS = 2,
    parameter logic [CTR_BITS-1:0] INIT = '1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                inc_i,
    output logic [CTR_BITS-1:0] ctr_o
);
    localparam logic [CTR_BITS-1:0] MAX = '1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctr_o <= INIT;
        end else if (en_i) begin
            if (inc_i) begin
                if (ctr_o != MAX) ctr_o <= ctr_o + 1'b1;
            end else if (ctr_o != '0) begin
                ctr_o <= ctr_o - 1'b1;
            end
        end
    end
endmodule

module gshare_branch_predictor #(
    parameter int INDEX_BITS = 4,
    parameter int CTR_BITS   = 2,
    parameter int GHR_BITS   = 4,
    parameter bit GSHARE     = 1'b1,
    parameter int INIT_CTR   = (1 << CTR_BITS) - 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           lookup_pc_i,
    output logic                  predict_o,
    output logic [INDEX_BITS-1:0] predict_idx_o,
    input  logic                  update_i,
    input  logic [INDEX_BITS-1:0] update_idx_i,
    input  logic                  update_pred_i,
    input  logic                  result_i,
    output logic                  mispredict_o,
    output logic [GHR_BITS-1:0]   ghr_o,
    output logic [31:0]           branch_cnt_o,
    output logic [31:0]           mispredict_cnt_o
);
    localparam int DEPTH = 1 << INDEX_BITS;
    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(INIT_CTR);

    logic [DEPTH-1:0][CTR_BITS-1:0] ctr;
    logic [GHR_BITS-1:0]            ghr_q;
    logic [GHR_BITS-1:0]            ghr_nxt;
    logic [INDEX_BITS-1:0]          pc_idx;
    logic [INDEX_BITS-1:0]          ghr_ext;
    logic                           unused_pc;

    assign pc_idx    = lookup_pc_i[INDEX_BITS+1:2];
    assign ghr_ext   = INDEX_BITS'(ghr_q);
    assign unused_pc = ^{lookup_pc_i[31:INDEX_BITS+2], lookup_pc_i[1:0]};

    assign predict_idx_o = GSHARE ? (pc_idx ^ ghr_ext) : pc_idx;
    // No bypass: a same-cycle update to this index shows up only next cycle.
    assign predict_o     = ctr[predict_idx_o][CTR_BITS-1];
    assign mispredict_o  = update_i & (update_pred_i ^ result_i);
    assign ghr_o         = ghr_q;

    generate
        for (genvar e = 0; e < DEPTH; e++) begin : g_pht
            pht_ctr #(.CTR_BITS(CTR_BITS), .INIT(INIT_VAL)) u_ctr (
                .clk_i (clk_i),
                .rst_i (rst_i),
                .en_i  (update_i && (update_idx_i == INDEX_BITS'(e))),
                .inc_i (result_i),
                .ctr_o (ctr[e])
            );
        end

        if (GHR_BITS == 1) begin : g_ghr1
            assign ghr_nxt = result_i;
        end else begin : g_ghrn
            assign ghr_nxt = {ghr_q[GHR_BITS-2:0], result_i};
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ghr_q            <= '0;
            branch_cnt_o     <= '0;
            mispredict_cnt_o <= '0;
        end else if (update_i) begin
            ghr_q        <= ghr_nxt;
            branch_cnt_o <= branch_cnt_o + 32'd1;
            if (mispredict_o) mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
        end
    end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Three predictor configurations driven in lockstep and checked against a
// behavioural table/history model, plus directed vectors for the corner cases.

module tb_gshare_branch_predictor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        upd = 1'b0;
    logic [3:0]  uidx = '0;
    logic        upred = 1'b0;
    logic        res = 1'b0;

    logic        pred_v[3];
    logic [3:0]  idx_v[3];
    logic        mis_v[3];
    logic [31:0] bc_v[3];
    logic [31:0] mc_v[3];
    logic [3:0]  ghr_a, ghr_b;
    logic [2:0]  ghr_c;

    int checks = 0;
    int failures = 0;

    int m_pht[3][16];
    int m_ghr[3];
    int m_bc[3];
    int m_mc[3];

    always #5 clk = ~clk;

    gshare_branch_predictor #(.GSHARE(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred_v[0]),
        .predict_idx_o(idx_v[0]), .update_i(upd), .update_idx_i(uidx),
        .update_pred_i(upred), .result_i(res), .mispredict_o(mis_v[0]),
        .ghr_o(ghr_a), .branch_cnt_o(bc_v[0]), .mispredict_cnt_o(mc_v[0]));

    gshare_branch_predictor #(.GSHARE(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred_v[1]),
        .predict_idx_o(idx_v[1]), .update_i(upd), .update_idx_i(uidx),
        .update_pred_i(upred), .result_i(res), .mispredict_o(mis_v[1]),
        .ghr_o(ghr_b), .branch_cnt_o(bc_v[1]), .mispredict_cnt_o(mc_v[1]));

    gshare_branch_predictor #(.CTR_BITS(3), .GHR_BITS(3), .GSHARE(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .lookup_pc_i(pc), .predict_o(pred_v[2]),
        .predict_idx_o(idx_v[2]), .update_i(upd), .update_idx_i(uidx),
        .update_pred_i(upred), .result_i(res), .mispredict_o(mis_v[2]),
        .ghr_o(ghr_c), .branch_cnt_o(bc_v[2]), .mispredict_cnt_o(mc_v[2]));

    function automatic int cfg_cb(int i); return (i == 2) ? 3 : 2; endfunction
    function automatic int cfg_gb(int i); return (i == 2) ? 3 : 4; endfunction
    function automatic bit cfg_gs(int i); return (i != 1); endfunction

    function automatic int dut_ghr(int i);
        if (i == 0) return int'(ghr_a);
        if (i == 1) return int'(ghr_b);
        return int'(ghr_c);
    endfunction

    function automatic int m_idx(int i);
        int p;
        p = (int'(pc) >> 2) % 16;
        return cfg_gs(i) ? (p ^ m_ghr[i]) : p;
    endfunction

    function automatic int m_pred(int i);
        return (m_pht[i][m_idx(i)] >= (1 << (cfg_cb(i) - 1))) ? 1 : 0;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_clock();
        for (int i = 0; i < 3; i++) begin
            int top;
            top = (1 << cfg_cb(i)) - 1;
            if (!rst) begin
                for (int e = 0; e < 16; e++) m_pht[i][e] = top;
                m_ghr[i] = 0;
                m_bc[i] = 0;
                m_mc[i] = 0;
            end else if (upd) begin
                if (res) m_pht[i][uidx] = (m_pht[i][uidx] < top) ? m_pht[i][uidx] + 1 : top;
                else     m_pht[i][uidx] = (m_pht[i][uidx] > 0) ? m_pht[i][uidx] - 1 : 0;
                m_ghr[i] = ((m_ghr[i] << 1) | int'(res)) % (1 << cfg_gb(i));
                m_bc[i]++;
                if (upred != res) m_mc[i]++;
            end
        end
    endtask

    task automatic settle_check();
        #2;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("pred%0d", i), pred_v[i], m_pred(i));
            check($sformatf("idx%0d", i), idx_v[i], m_idx(i));
            check($sformatf("ghr%0d", i), dut_ghr(i), m_ghr[i]);
            check($sformatf("bcnt%0d", i), bc_v[i], m_bc[i]);
            check($sformatf("mcnt%0d", i), mc_v[i], m_mc[i]);
            check($sformatf("mis%0d", i), mis_v[i], (upd && (upred != res)) ? 1 : 0);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; upd = 1'b1; res = 1'b1; upred = 1'b0;
        edge_step();
        rst = 1'b1; upd = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          upd;
        logic [3:0]  uidx;
        bit          upred;
        bit          res;
        bit          e_pred_b;
        int          e_idx_a;
        int          e_ghr_a;
        bit          e_mis;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{32'h10, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1,  4,  0, 1'b0};
        tv[1]  = '{32'h10, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1,  4,  0, 1'b1};
        tv[2]  = '{32'h10, 1'b1, 4'd4, 1'b1, 1'b0, 1'b1,  4,  0, 1'b1};
        tv[3]  = '{32'h10, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0,  4,  0, 1'b0};
        tv[4]  = '{32'h10, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0,  4,  0, 1'b0};
        tv[5]  = '{32'h10, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0,  4,  0, 1'b1};
        tv[6]  = '{32'h10, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,  5,  1, 1'b0};
        tv[7]  = '{32'h10, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0,  5,  1, 1'b0};
        tv[8]  = '{32'h10, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0,  7,  3, 1'b0};
        tv[9]  = '{32'h10, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0,  3,  7, 1'b1};
        tv[10] = '{32'h10, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 10, 14, 1'b0};
        tv[11] = '{32'h08, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 15, 13, 1'b0};

        // Reset held two cycles with an update pending.
        rst = 1'b0; upd = 1'b1; res = 1'b1; uidx = 4'd3;
        edge_step();
        settle_check();
        edge_step();
        rst = 1'b1; upd = 1'b0;
        for (int e = 0; e < 16; e++) begin
            pc = 32'(e * 4);
            settle_check();
            check("rst_pred_a", pred_v[0], 1);
            check("rst_pred_c", pred_v[2], 1);
            edge_step();
        end
        check("rst_ghr_a", ghr_a, 0);
        check("rst_bcnt_a", bc_v[0], 0);
        check("rst_mcnt_a", mc_v[0], 0);

        // Saturation (bimodal) then gshare indexing.
        foreach (tv[k]) begin
            pc = tv[k].pc; upd = tv[k].upd; uidx = tv[k].uidx;
            upred = tv[k].upred; res = tv[k].res;
            settle_check();
            check($sformatf("tv%0d_pred_b", k), pred_v[1], tv[k].e_pred_b);
            check($sformatf("tv%0d_idx_a", k), idx_v[0], tv[k].e_idx_a);
            check($sformatf("tv%0d_ghr_a", k), ghr_a, tv[k].e_ghr_a);
            check($sformatf("tv%0d_mis", k), mis_v[0], tv[k].e_mis);
            edge_step();
        end

        // Mispredict statistics: wrong on updates 3, 7 and 10.
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            bit wrong;
            wrong = (k == 3 || k == 7 || k == 10);
            upd = 1'b1; uidx = 4'($urandom_range(0, 15)); res = 1'($urandom);
            upred = res ^ wrong;
            settle_check();
            check($sformatf("stat_mis%0d", k), mis_v[0], wrong);
            edge_step();
        end
        upd = 1'b0;
        settle_check();
        check("stat_bcnt", bc_v[0], 10);
        check("stat_mcnt", mc_v[0], 3);

        // Same-cycle lookup/update on bimodal idx 5 with counter at 2.
        do_reset();
        pc = 32'h14; upd = 1'b1; uidx = 4'd5; res = 1'b0; upred = 1'b1;
        edge_step();
        settle_check();
        check("haz_pred_same", pred_v[1], 1);
        edge_step();
        upd = 1'b0;
        settle_check();
        check("haz_pred_next", pred_v[1], 0);

        // Mid-stream reset on the 3-bit counter config, concurrent update lost.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            upd = 1'b1; uidx = 4'd1; res = 1'(k == 2); upred = 1'b1;
            settle_check();
            edge_step();
        end
        rst = 1'b0; upd = 1'b1; uidx = 4'd1; res = 1'b1;
        edge_step();
        rst = 1'b1; upd = 1'b0;
        settle_check();
        check("mid_ghr_c", ghr_c, 0);
        check("mid_bcnt_c", bc_v[2], 0);
        check("mid_mcnt_c", mc_v[2], 0);
        for (int e = 0; e < 16; e++) begin
            pc = 32'(e * 4);
            #1;
            check($sformatf("mid_pred_c%0d", e), pred_v[2], 1);
        end
        // Counter at 7: three decrements keep MSB set, the fourth clears it.
        pc = 32'h24; uidx = 4'd9; res = 1'b0; upred = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            upd = 1'b1;
            edge_step();
            upd = 1'b0;
            settle_check();
            check($sformatf("mid_dec%0d", k), pred_v[2], (k < 4) ? 1 : 0);
        end

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) != 0);
            pc = $urandom;
            upd = 1'($urandom);
            uidx = 4'($urandom);
            upred = 1'($urandom);
            res = 1'($urandom);
            settle_check();
            edge_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
